fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ihit  input  1  icache returns valid instruction this cycle.
REQ-005 SHALL have port: iload  input  32  instruction word from icache.
REQ-006 SHALL have port: imemREN  output  1  instruction read request.
REQ-007 SHALL have port: imemaddr  output  32  instruction fetch address (current PC).
REQ-008 SHALL have port: stall  input  1  hazard unit hold of PC and IF/ID latch.
REQ-009 SHALL have port: flush  input  1  squash IF/ID contents (taken branch/jump).
REQ-010 SHALL have port: pc_load  input  1  redirect PC to pc_target.
REQ-011 SHALL have port: pc_target  input  32  redirect address.
REQ-012 SHALL have port: halt  input  1  halt indication from control unit.
REQ-013 SHALL have ports: ifid_valid  output  1; ifid_instr  output  32; ifid_npc  output  32  IF/ID latch contents.
REQ-014 SHALL have ports: opcode  output  6  ifid_instr[31:26]; funct  output  6  ifid_instr[5:0]; both combinational from the latch, feeding the control unit.

Function
REQ-015 SHALL implement a two-state FSM, RUN and HALTED; RUN -> HALTED on a cycle with halt=1; HALTED exits only via RST.
REQ-016 SHALL drive imemREN=1 in RUN, 0 in HALTED; imemaddr=PC always.
REQ-017 SHALL update PC in RUN with priority: pc_load -> pc_target (regardless of ihit/stall); else ihit&&!stall -> PC+4; else hold.
REQ-018 SHALL compute PC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-019 SHALL update IF/ID in RUN with priority: flush||pc_load -> valid=0, instr=0, npc=0; else stall -> hold; else ihit -> valid=1, instr=iload, npc=PC+4; else bubble (valid=0, instr=0, npc=0).
REQ-020 SHALL discard an instruction whose ihit coincides with pc_load or flush (no IF/ID capture, no PC+4).
REQ-021 SHALL, when halt and pc_load coincide, enter HALTED with PC unchanged.
REQ-022 SHALL, in HALTED, hold PC and force ifid_valid=0, ifid_instr=0, ifid_npc=0.
REQ-023 SHALL have one-cycle latency: iload captured on edge k appears on ifid_instr after edge k.
REQ-024 SHALL ignore ihit when imemREN=0.

Reset
REQ-025 SHALL on RST=1 at a rising edge set PC=PC_INIT, state=RUN, ifid_valid=0, ifid_instr=0, ifid_npc=0, counters=0.
REQ-026 SHALL give RST priority over every other input, including mid-fetch and in HALTED; imemaddr=PC_INIT the cycle after reset.

Configuration
REQ-027 SHALL, with FETCH_PERF_EN defined, add outputs fetch_count (32) and stall_cycles (32).
REQ-028 fetch_count SHALL increment on each IF/ID capture of a valid instruction (REQ-019 ihit branch).
REQ-029 stall_cycles SHALL increment each RUN cycle with (imemREN&&!ihit)||stall.
REQ-030 Both counters SHALL saturate at 0xFFFFFFFF and freeze in HALTED.
REQ-031 SHALL, without FETCH_PERF_EN, omit these ports and counters entirely; all other behaviour identical.

Verification
REQ-032 Reset, then ihit=1 with iload=0x8C220004 for 3 cycles -> imemaddr 0x0,0x4,0x8; ifid_instr=0x8C220004, ifid_npc=0x4 after first edge, opcode=6'h23.
REQ-033 ihit=1, stall=1 for 2 cycles -> PC and IF/ID unchanged; stall_cycles +2 (FETCH_PERF_EN).
REQ-034 pc_load=1, pc_target=0x00000100, ihit=1 same cycle -> next PC=0x100, ifid_valid=0, ifid_instr=0.
REQ-035 PC=0xFFFFFFFC, ihit=1 -> next PC=0x00000000, ifid_npc=0x00000000.
REQ-036 halt=1 with pc_load=1 -> next cycle imemREN=0, PC unchanged, ifid_valid=0; remains so until RST=1, then imemaddr=PC_INIT.
REQ-037 ihit=0 for 4 cycles in RUN -> PC held, ifid_valid=0 each cycle, imemREN=1.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage and the icache.
interface fetch_stage_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] iload;

    modport master (output imemREN, output imemaddr, input ihit, input iload);
    modport slave  (input imemREN, input imemaddr, output ihit, output iload);
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, RUN/HALTED control and the IF/ID latch.
// Optional FETCH_PERF_EN adds saturating fetch_count and stall_cycles counters.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic                 CLK,
    input  logic                 RST,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 pc_load,
    input  logic [31:0]          pc_target,
    input  logic                 halt,
    output logic                 ifid_valid,
    output logic [31:0]          ifid_instr,
    output logic [31:0]          ifid_npc,
    output logic [5:0]           opcode,
    output logic [5:0]           funct
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_r, state_next_s;
    logic [31:0] pc_r, pc_next_s, pc_plus4_s;
    logic        ifid_valid_r, ifid_valid_next_s;
    logic [31:0] ifid_instr_r, ifid_instr_next_s;
    logic [31:0] ifid_npc_r, ifid_npc_next_s;
    logic        capture_s;

    assign pc_plus4_s    = pc_r + 32'd4;
    assign imem.imemREN  = (state_r == RUN);
    assign imem.imemaddr = pc_r;
    assign ifid_valid    = ifid_valid_r;
    assign ifid_instr    = ifid_instr_r;
    assign ifid_npc      = ifid_npc_r;
    assign opcode        = ifid_instr_r[31:26];
    assign funct         = ifid_instr_r[5:0];

    // Next-state, PC and IF/ID selection; halt wins over redirect so PC stays put.
    always_comb begin
        state_next_s      = state_r;
        pc_next_s         = pc_r;
        ifid_valid_next_s = 1'b0;
        ifid_instr_next_s = 32'h00000000;
        ifid_npc_next_s   = 32'h00000000;
        capture_s         = 1'b0;
        case (state_r)
            RUN: begin
                if (halt) begin
                    state_next_s = HALTED;
                end else begin
                    if (pc_load) begin
                        pc_next_s = pc_target;
                    end else if (imem.ihit && !stall && !flush) begin
                        pc_next_s = pc_plus4_s;
                    end else begin
                        pc_next_s = pc_r;
                    end
                    if (flush || pc_load) begin
                        ifid_valid_next_s = 1'b0;
                    end else if (stall) begin
                        ifid_valid_next_s = ifid_valid_r;
                        ifid_instr_next_s = ifid_instr_r;
                        ifid_npc_next_s   = ifid_npc_r;
                    end else if (imem.ihit) begin
                        ifid_valid_next_s = 1'b1;
                        ifid_instr_next_s = imem.iload;
                        ifid_npc_next_s   = pc_plus4_s;
                        capture_s         = 1'b1;
                    end else begin
                        ifid_valid_next_s = 1'b0;
                    end
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                state_next_s = RUN;
                pc_next_s    = PC_INIT;
            end
        endcase
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= RUN;
            pc_r         <= PC_INIT;
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'h00000000;
            ifid_npc_r   <= 32'h00000000;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            ifid_valid_r <= ifid_valid_next_s;
            ifid_instr_r <= ifid_instr_next_s;
            ifid_npc_r   <= ifid_npc_next_s;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r, stall_cycles_r;
    logic        stall_inc_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFFFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

    assign stall_inc_s  = (state_r == RUN) && ((imem.imemREN && !imem.ihit) || stall);
    assign fetch_count  = fetch_count_r;
    assign stall_cycles = stall_cycles_r;

    // Saturating performance counters; both freeze once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count_r  <= 32'h00000000;
            stall_cycles_r <= 32'h00000000;
        end else begin
            if (capture_s) begin
                fetch_count_r <= sat_inc(fetch_count_r);
            end else begin
                fetch_count_r <= fetch_count_r;
            end
            if (stall_inc_s) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; build with FETCH_PERF_EN to also check counters.
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, flush, pc_load, halt;
    logic [31:0] pc_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_npc;
    logic [5:0]  opcode, funct;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_cycles;
    logic [31:0] stall_base;
`endif
    int checks = 0;
    int failures = 0;

    fetch_stage_if imem ();

    fetch_stage #(.PC_INIT(32'h00000000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imem       (imem.master),
        .stall      (stall),
        .flush      (flush),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .halt       (halt),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .opcode     (opcode),
        .funct      (funct)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; imem.ihit = 1'b1; imem.iload = 32'hDEADBEEF;
        stall = 1'b0; flush = 1'b0; pc_load = 1'b1; pc_target = 32'h00000040; halt = 1'b0;
        step(); step();
        RST = 1'b0; pc_load = 1'b0; imem.ihit = 1'b0;
        checks++;
        if (imem.imemaddr !== 32'h00000000) begin
            failures++; $display("FAIL reset_addr actual=%h required=%h", imem.imemaddr, 32'h00000000);
        end
        checks++;
        if (imem.imemREN !== 1'b1 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_npc !== 32'h0) begin
            failures++; $display("FAIL reset_state actual=%b/%b/%h/%h required=1/0/0/0",
                                 imem.imemREN, ifid_valid, ifid_instr, ifid_npc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_count !== 32'h0 || stall_cycles !== 32'h0) begin
            failures++; $display("FAIL reset_counters actual=%h/%h required=0/0", fetch_count, stall_cycles);
        end
`endif
    endtask

    task automatic test_fetch();
        imem.ihit = 1'b1; imem.iload = 32'h8C220004;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem.imemaddr !== 32'(4 * i)) begin
                failures++; $display("FAIL fetch_addr%0d actual=%h required=%h", i, imem.imemaddr, 32'(4 * i));
            end
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C220004 || ifid_npc !== 32'(4 * (i + 1))) begin
                failures++; $display("FAIL fetch_ifid%0d actual=%b/%h/%h required=1/8c220004/%h",
                                     i, ifid_valid, ifid_instr, ifid_npc, 32'(4 * (i + 1)));
            end
        end
        checks++;
        if (opcode !== 6'h23 || funct !== 6'h04) begin
            failures++; $display("FAIL fetch_decode actual=%h/%h required=23/04", opcode, funct);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_count !== 32'd3) begin
            failures++; $display("FAIL fetch_count actual=%0d required=3", fetch_count);
        end
`endif
    endtask

    task automatic test_stall();
`ifdef FETCH_PERF_EN
        stall_base = stall_cycles;
`endif
        stall = 1'b1; imem.ihit = 1'b1; imem.iload = 32'h12345678;
        step(); step();
        stall = 1'b0; imem.ihit = 1'b0;
        checks++;
        if (imem.imemaddr !== 32'h0000000C) begin
            failures++; $display("FAIL stall_pc actual=%h required=%h", imem.imemaddr, 32'h0000000C);
        end
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C220004 || ifid_npc !== 32'h0000000C) begin
            failures++; $display("FAIL stall_ifid actual=%b/%h/%h required=1/8c220004/0000000c",
                                 ifid_valid, ifid_instr, ifid_npc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (stall_cycles !== stall_base + 32'd2) begin
            failures++; $display("FAIL stall_cycles actual=%0d required=%0d", stall_cycles, stall_base + 32'd2);
        end
`endif
    endtask

    task automatic test_redirect();
        pc_load = 1'b1; pc_target = 32'h00000100; imem.ihit = 1'b1; imem.iload = 32'hAAAA5555;
        step();
        pc_load = 1'b0;
        checks++;
        if (imem.imemaddr !== 32'h00000100 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
            failures++; $display("FAIL redirect actual=%h/%b/%h required=00000100/0/0",
                                 imem.imemaddr, ifid_valid, ifid_instr);
        end
        flush = 1'b1;
        step();
        flush = 1'b0; imem.ihit = 1'b0;
        checks++;
        if (imem.imemaddr !== 32'h00000100 || ifid_valid !== 1'b0 || ifid_npc !== 32'h0) begin
            failures++; $display("FAIL flush actual=%h/%b/%h required=00000100/0/0",
                                 imem.imemaddr, ifid_valid, ifid_npc);
        end
    endtask

    task automatic test_bubble();
        imem.ihit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (imem.imemaddr !== 32'h00000100 || ifid_valid !== 1'b0 || imem.imemREN !== 1'b1) begin
                failures++; $display("FAIL bubble%0d actual=%h/%b/%b required=00000100/0/1",
                                     i, imem.imemaddr, ifid_valid, imem.imemREN);
            end
        end
    endtask

    task automatic test_wrap();
        pc_load = 1'b1; pc_target = 32'hFFFFFFFC;
        step();
        pc_load = 1'b0; imem.ihit = 1'b1; imem.iload = 32'h00000020;
        checks++;
        if (imem.imemaddr !== 32'hFFFFFFFC) begin
            failures++; $display("FAIL wrap_load actual=%h required=fffffffc", imem.imemaddr);
        end
        step();
        checks++;
        if (imem.imemaddr !== 32'h00000000 || ifid_npc !== 32'h00000000 || ifid_valid !== 1'b1) begin
            failures++; $display("FAIL wrap actual=%h/%h/%b required=0/0/1", imem.imemaddr, ifid_npc, ifid_valid);
        end
        checks++;
        if (opcode !== 6'h00 || funct !== 6'h20) begin
            failures++; $display("FAIL wrap_decode actual=%h/%h required=00/20", opcode, funct);
        end
        step();
    endtask

    task automatic test_halt();
        halt = 1'b1; pc_load = 1'b1; pc_target = 32'h00000200; imem.ihit = 1'b1;
        step();
        halt = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem.imemREN !== 1'b0 || imem.imemaddr !== 32'h00000004 || ifid_valid !== 1'b0 ||
                ifid_instr !== 32'h0) begin
                failures++; $display("FAIL halted%0d actual=%b/%h/%b/%h required=0/00000004/0/0",
                                     i, imem.imemREN, imem.imemaddr, ifid_valid, ifid_instr);
            end
            step();
        end
        RST = 1'b1; pc_load = 1'b1; pc_target = 32'h00000300;
        step();
        RST = 1'b0; pc_load = 1'b0; imem.ihit = 1'b0;
        checks++;
        if (imem.imemaddr !== 32'h00000000 || imem.imemREN !== 1'b1) begin
            failures++; $display("FAIL halt_reset actual=%h/%b required=00000000/1", imem.imemaddr, imem.imemREN);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_bubble();
        test_wrap();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
